// File: rtl/fullsend_pkg.sv
// Shared decode constants and types for the Fullsend pipeline.
package fullsend_pkg;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [2:0]  F3_B     = 3'b000;
  localparam logic [2:0]  F3_H     = 3'b001;
  localparam logic [2:0]  F3_W     = 3'b010;
  localparam logic [2:0]  F3_BU    = 3'b100;
  localparam logic [2:0]  F3_HU    = 3'b101;
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replicated data and load extract/extend.
module mem_lane_align
  import fullsend_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);
  logic [31:0] rsh;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = rs2_i;
    case (funct3_i[1:0])
      2'b00: begin be_o = 4'b0001 << lane_i; wdata_o = {4{rs2_i[7:0]}};  end
      2'b01: begin be_o = 4'b0011 << lane_i; wdata_o = {2{rs2_i[15:0]}}; end
      default: ;
    endcase
  end

  // Shifting the word down keeps every lane's slice in range.
  assign rsh = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    case (funct3_i)
      F3_B:    ld_data_o = {{24{rsh[7]}}, rsh[7:0]};
      F3_H:    ld_data_o = {{16{rsh[15]}}, rsh[15:0]};
      F3_BU:   ld_data_o = {24'h0, rsh[7:0]};
      F3_HU:   ld_data_o = {16'h0, rsh[15:0]};
      default: ld_data_o = rsh;
    endcase
  end
endmodule

// File: rtl/stage4_mem.sv
// MEM stage: data-memory handshake, stall generation, MEM/WB register.
module stage4_mem
  import fullsend_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0][31:0] ex_mem,
  input  logic             ex_valid,
  output logic             mem_stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic [3:0][31:0] mem_wb,
  output logic             mem_wb_valid,
  output logic [31:0]      fwd_mem,
  output logic             misaligned,
  output logic             bus_err
);
  localparam int CW = $clog2(WAIT_MAX + 1);

  mem_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0][31:0] mem_wb_q;
  logic             valid_q, misal_q, misal_d, berr_q, berr_d, commit;
  logic [31:0]      ir, ea, ld_data;
  logic [3:0]       be;
  logic             is_load, is_store, memop, misal, timeout;
  logic             unused_cond;

  assign ir          = ex_mem[0];
  assign ea          = ex_mem[2];
  assign unused_cond = ^ex_mem[1];
  assign is_load     = (ir[6:0] == OP_LOAD);
  assign is_store    = (ir[6:0] == OP_STORE);
  assign memop       = is_load | is_store;
  assign misal       = ((ir[13:12] == 2'b01) & ea[0]) | (ir[13] & (|ea[1:0]));
  assign timeout     = (state_q == WAIT) && (cnt_q == CW'(WAIT_MAX));

  mem_lane_align u_align (
    .lane_i    (ea[1:0]),
    .funct3_i  (ir[14:12]),
    .rs2_i     (ex_mem[3]),
    .rdata_i   (dmem_rdata),
    .be_o      (be),
    .wdata_o   (dmem_wdata),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dmem_req = 1'b0;
    commit   = 1'b0;
    misal_d  = 1'b0;
    berr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        dmem_req = ex_valid & memop & ~misal;
        misal_d  = ex_valid & memop & misal;
        commit   = ex_valid & (~memop | (~misal & dmem_ack));
        if (dmem_req && !dmem_ack) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // Timeout cycle drops req so the stall releases and the op is discarded.
        if (timeout) begin
          berr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          dmem_req = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (dmem_ack) begin
            commit  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
    if (reset) dmem_req = 1'b0;
  end

  assign mem_stall = dmem_req & ~dmem_ack;
  assign dmem_we   = is_store;
  assign dmem_be   = is_store ? be : 4'b0000;
  assign dmem_addr = {ea[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mem_wb_q <= '0;
      valid_q  <= 1'b0;
      misal_q  <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= commit;
      misal_q <= misal_d;
      berr_q  <= berr_d;
      if (commit) mem_wb_q <= {32'h0, (is_load ? ld_data : 32'h0), ea, ir};
      else        mem_wb_q <= {32'h0, 32'h0, 32'h0, NOP_INSN};
    end
  end

  assign mem_wb       = mem_wb_q;
  assign mem_wb_valid = valid_q;
  assign misaligned   = misal_q;
  assign bus_err      = berr_q;
  assign fwd_mem      = (mem_wb_q[0][6:0] == OP_LOAD) ? mem_wb_q[2] : mem_wb_q[1];
endmodule

// File: tb/tb_stage4_mem.sv
// Directed and randomized checks of stage4_mem against a behavioural model.
module tb_stage4_mem;
  logic             clk = 1'b0;
  logic             reset;
  logic [3:0][31:0] ex_mem;
  logic             ex_valid;
  logic             mem_stall, dmem_req, dmem_we;
  logic [31:0]      dmem_addr, dmem_wdata, dmem_rdata, fwd_mem;
  logic [3:0]       dmem_be;
  logic             dmem_ack;
  logic [3:0][31:0] mem_wb;
  logic             mem_wb_valid, misaligned, bus_err;
  int               total = 0;
  int               bad = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  stage4_mem #(.WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset), .ex_mem(ex_mem), .ex_valid(ex_valid),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_wb(mem_wb),
    .mem_wb_valid(mem_wb_valid), .fwd_mem(fwd_mem),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic present(input logic [31:0] ir, input logic [31:0] ea,
                         input logic [31:0] rs2, input logic v);
    ex_mem[0] = ir; ex_mem[1] = $urandom; ex_mem[2] = ea; ex_mem[3] = rs2;
    ex_valid = v;
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lane,
                                         input logic [31:0] w);
    longint unsigned sh, b, h;
    sh = longint'(w) / (64'd1 << (8 * lane));
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h) + 32'hFFFF_0000 : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    present(32'h00052583, 32'h40, 32'h0, 1'b1);
    #3;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
    step(); step();
    total++; if (mem_wb !== '0 || mem_wb_valid !== 1'b0)
      begin bad++; $display("FAIL rst_mem_wb got=%h v=%b exp=0", mem_wb, mem_wb_valid); end
    total++; if (misaligned !== 1'b0 || bus_err !== 1'b0)
      begin bad++; $display("FAIL rst_pulses got mis=%b berr=%b exp=0", misaligned, bus_err); end
    reset = 1'b0; ex_valid = 1'b0;
    step();
  endtask

  task automatic test_alu();
    present(32'h00B50533, 32'h0000_1234, 32'h55, 1'b1);
    #3;
    total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
      begin bad++; $display("FAIL alu_req got req=%b stall=%b exp=0", dmem_req, mem_stall); end
    step();
    total++; if (mem_wb[1] !== 32'h1234 || mem_wb_valid !== 1'b1 || mem_wb[0] !== 32'h00B50533)
      begin bad++; $display("FAIL alu_wb got=%h v=%b exp=1234 v=1", mem_wb[1], mem_wb_valid); end
    total++; if (fwd_mem !== 32'h1234) begin bad++; $display("FAIL alu_fwd got=%h exp=1234", fwd_mem); end
    ex_valid = 1'b0;
    step();
  endtask

  task automatic test_lb_wait();
    present(32'h00050583, 32'h103, 32'h0, 1'b1);
    dmem_rdata = 32'h80FF_0000;
    for (int k = 0; k <= 3; k++) begin
      dmem_ack = (k == 3);
      #3;
      total++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || mem_stall !== (k < 3) || dmem_be !== 4'b0)
        begin bad++; $display("FAIL lb_hs k=%0d req=%b addr=%h stall=%b be=%b", k, dmem_req, dmem_addr, mem_stall, dmem_be); end
      step();
    end
    dmem_ack = 1'b0; ex_valid = 1'b0;
    total++; if (mem_wb[2] !== 32'hFFFF_FF80 || fwd_mem !== 32'hFFFF_FF80 || mem_wb_valid !== 1'b1)
      begin bad++; $display("FAIL lb_data got=%h fwd=%h exp=ffffff80", mem_wb[2], fwd_mem); end
    step();
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL lb_once got v=%b exp=0", mem_wb_valid); end
  endtask

  task automatic test_lhu_same();
    present(32'h00055583, 32'h102, 32'h0, 1'b1);
    dmem_rdata = 32'h9ABC_5678; dmem_ack = 1'b1;
    #3;
    total++; if (dmem_req !== 1'b1 || mem_stall !== 1'b0)
      begin bad++; $display("FAIL lhu_hs got req=%b stall=%b exp req=1 stall=0", dmem_req, mem_stall); end
    step();
    dmem_ack = 1'b0; ex_valid = 1'b0;
    total++; if (mem_wb[2] !== 32'h0000_9ABC || mem_wb_valid !== 1'b1)
      begin bad++; $display("FAIL lhu_data got=%h exp=00009abc", mem_wb[2]); end
    step();
  endtask

  task automatic test_sh();
    present(32'h00B51023, 32'h206, 32'hDEAD_BEEF, 1'b1);
    dmem_ack = 1'b1;
    #3;
    total++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEF_BEEF || dmem_we !== 1'b1 || dmem_addr !== 32'h204)
      begin bad++; $display("FAIL sh_bus got be=%b wd=%h we=%b addr=%h", dmem_be, dmem_wdata, dmem_we, dmem_addr); end
    step();
    dmem_ack = 1'b0; ex_valid = 1'b0;
    total++; if (mem_wb_valid !== 1'b1 || mem_wb[2] !== 32'h0)
      begin bad++; $display("FAIL sh_wb got v=%b d=%h exp v=1 d=0", mem_wb_valid, mem_wb[2]); end
    step();
  endtask

  task automatic test_misaligned();
    present(32'h00B52023, 32'h301, 32'h1, 1'b1);
    dmem_ack = 1'b1;
    #3;
    total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
      begin bad++; $display("FAIL mis_req got req=%b stall=%b exp=0", dmem_req, mem_stall); end
    step();
    dmem_ack = 1'b0; ex_valid = 1'b0;
    total++; if (misaligned !== 1'b1 || mem_wb[0] !== NOP || mem_wb_valid !== 1'b0)
      begin bad++; $display("FAIL mis_bubble got mis=%b ir=%h v=%b", misaligned, mem_wb[0], mem_wb_valid); end
    step();
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b exp=0", misaligned); end
  endtask

  task automatic test_timeout();
    present(32'h00052583, 32'h400, 32'h0, 1'b1);
    dmem_ack = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      #3;
      total++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1 || dmem_addr !== 32'h400 || bus_err !== 1'b0)
        begin bad++; $display("FAIL to_wait k=%0d req=%b stall=%b berr=%b", k, dmem_req, mem_stall, bus_err); end
      step();
    end
    #3;
    total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
      begin bad++; $display("FAIL to_drop got req=%b stall=%b exp=0", dmem_req, mem_stall); end
    step();
    ex_valid = 1'b0;
    total++; if (bus_err !== 1'b1 || mem_wb[0] !== NOP || mem_wb_valid !== 1'b0)
      begin bad++; $display("FAIL to_berr got berr=%b ir=%h v=%b", bus_err, mem_wb[0], mem_wb_valid); end
    step();
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b exp=0", bus_err); end
  endtask

  task automatic test_reset_in_wait();
    present(32'h00052583, 32'h500, 32'h0, 1'b1);
    dmem_ack = 1'b0;
    step(); step();
    reset = 1'b1;
    #3;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rw_req got=%b exp=0", dmem_req); end
    step();
    reset = 1'b0; ex_valid = 1'b0;
    total++; if (mem_wb !== '0 || mem_wb_valid !== 1'b0)
      begin bad++; $display("FAIL rw_wb got=%h v=%b exp=0", mem_wb, mem_wb_valid); end
    dmem_ack = 1'b1;
    #3;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rw_req2 got=%b exp=0", dmem_req); end
    step();
    dmem_ack = 1'b0;
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL rw_late_ack got v=%b exp=0", mem_wb_valid); end
    step();
  endtask

  task automatic test_random();
    logic [2:0]  ldf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] ir, ea, rs2, rd, exp_ld, exp_wd;
    logic [3:0]  exp_be;
    logic [2:0]  f3;
    int          kind, dly, sz;
    bit          mis;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      ea   = $urandom;
      if ($urandom_range(0, 3) != 0) ea[1:0] = 2'b00;
      rs2  = $urandom;
      rd   = $urandom;
      dly  = $urandom_range(0, 4);
      if (kind == 0) begin
        f3 = 3'($urandom);
        ir = {17'($urandom), f3, 5'($urandom), ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011};
      end else if (kind == 1) begin
        f3 = ldf3[$urandom_range(0, 4)];
        ir = {17'($urandom), f3, 5'($urandom), 7'b0000011};
      end else begin
        f3 = 3'($urandom_range(0, 2));
        ir = {17'($urandom), f3, 5'($urandom), 7'b0100011};
      end
      sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis = (kind != 0) && ((ea % sz) != 0);
      exp_be = (sz == 1) ? 4'(1 << ea[1:0]) : (sz == 2) ? 4'(3 << ea[1:0]) : 4'hF;
      exp_wd = (sz == 1) ? rs2[7:0] * 32'h0101_0101 : (sz == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
      exp_ld = m_load(f3, ea[1:0], rd);
      present(ir, ea, rs2, 1'b1);
      if (kind == 0 || mis) begin
        dmem_ack = $urandom_range(0, 1); dmem_rdata = $urandom;
        #3;
        total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
          begin bad++; $display("FAIL rnd_noreq n=%0d req=%b stall=%b", n, dmem_req, mem_stall); end
        step();
        dmem_ack = 1'b0;
        total++;
        if (mis ? (misaligned !== 1'b1 || mem_wb_valid !== 1'b0 || mem_wb[0] !== NOP)
                : (mem_wb_valid !== 1'b1 || mem_wb[1] !== ea || mem_wb[0] !== ir || fwd_mem !== ea))
          begin bad++; $display("FAIL rnd_pass n=%0d mis=%0d got v=%b ir=%h r=%h", n, mis, mem_wb_valid, mem_wb[0], mem_wb[1]); end
      end else begin
        for (int k = 0; k <= dly; k++) begin
          dmem_ack = (k == dly);
          dmem_rdata = (k == dly) ? rd : $urandom;
          #3;
          total++;
          if (dmem_req !== 1'b1 || mem_stall !== (k != dly) || dmem_addr !== {ea[31:2], 2'b00} ||
              dmem_we !== (kind == 2) || dmem_be !== ((kind == 2) ? exp_be : 4'b0) ||
              (kind == 2 && dmem_wdata !== exp_wd))
            begin bad++; $display("FAIL rnd_bus n=%0d k=%0d req=%b stall=%b addr=%h be=%b wd=%h exp be=%b wd=%h",
                                  n, k, dmem_req, mem_stall, dmem_addr, dmem_be, dmem_wdata, exp_be, exp_wd); end
          step();
        end
        dmem_ack = 1'b0;
        total++;
        if (mem_wb_valid !== 1'b1 || mem_wb[0] !== ir || mem_wb[1] !== ea ||
            mem_wb[2] !== ((kind == 1) ? exp_ld : 32'h0) || fwd_mem !== ((kind == 1) ? exp_ld : ea))
          begin bad++; $display("FAIL rnd_wb n=%0d got v=%b d=%h fwd=%h exp d=%h", n, mem_wb_valid, mem_wb[2], fwd_mem, exp_ld); end
      end
      if ($urandom_range(0, 3) == 0) begin
        ex_valid = 1'b0;
        step();
        total++; if (mem_wb_valid !== 1'b0 || mem_wb[0] !== NOP)
          begin bad++; $display("FAIL rnd_idle n=%0d got v=%b ir=%h", n, mem_wb_valid, mem_wb[0]); end
      end
    end
    ex_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb_wait();
    test_lhu_same();
    test_sh();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stage4_mem.md
# stage4_mem

Memory-access stage of the Fullsend five-stage pipeline, between EX and WB. It consumes the EX/MEM register array and issues loads and stores to the data-memory port with a req/ack handshake. It aligns and extends load data, generates store byte enables, and stalls upstream while an access is outstanding. It produces the MEM/WB register array and the MEM-stage forwarding value.

## Interface
- `WAIT_MAX`, default 255: maximum cycles in WAIT before the access is aborted; must be ≥1.
- `clk  in  1`: clock.
- `reset  in  1`: synchronous, active-high.
- `ex_mem  in  32 x [3:0]`: [0] IR, [1] COND (ignored), [2] ALU result / effective address, [3] store data (rs2).
- `ex_valid  in  1`: `ex_mem` holds a live instruction; all `ex_mem` fields are don't-care when low.
- `mem_stall  out  1`: hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `dmem_req  out  1`: access request, held until ack.
- `dmem_we  out  1`: 1 = store.
- `dmem_addr  out  32`: word address, {ea[31:2],2'b00}.
- `dmem_be  out  4`: byte enables (stores), 4'b0000 on loads.
- `dmem_wdata  out  32`: lane-replicated store data.
- `dmem_ack  in  1`: access complete; `dmem_rdata` valid the same cycle for loads.
- `dmem_rdata  in  32`: load word.
- `mem_wb  out  32 x [3:0]`: [0] IR, [1] ALU result, [2] extended load data, [3] reserved, 0.
- `mem_wb_valid  out  1`: `mem_wb` holds an instruction to commit.
- `fwd_mem  out  32`: combinational; load data when `mem_wb[0]` is a load, else `mem_wb[1]`.
- `misaligned  out  1`: one-cycle pulse on a misaligned access.
- `bus_err  out  1`: one-cycle pulse on a WAIT_MAX timeout.

## Operation
- Decode from IR: opcode IR[6:0], 7'b0000011 = load and 7'b0100011 = store; funct3 IR[14:12].
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- Lane = ea[1:0].
- Misaligned when ea[0]=1 for any halfword, or ea[1:0]≠0 for any word.
  - No request is issued; `misaligned` pulses.
  - The MEM/WB register loads a bubble: IR = 32'h00000013, valid 0.
- Store enables and data:
  - SB: be = 4'b0001<<lane, wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011<<lane, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
- Load extraction: byte = rdata[8*lane+:8] and half = rdata[8*lane+:16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word.
- FSM, two states:
  - **IDLE**: `dmem_req` = ex_valid & memop & aligned, combinational from `ex_mem`. If ack arrives the same cycle, the access completes with no stall. If req is high without ack, go to WAIT.
  - **WAIT**: req, we, addr, be and wdata are held constant (EX/MEM is frozen by the stall). On ack, return to IDLE. If the counter reaches WAIT_MAX without ack, drop req, pulse `bus_err`, load a bubble, and return to IDLE.
- `mem_stall` = dmem_req & ~dmem_ack.
- Non-memory valid instructions pass through with no stall.
- MEM/WB update every cycle:
  - completed access or non-mem instruction → valid 1;
  - stall, misaligned, timeout or ~ex_valid → bubble.
- An instruction is never committed twice.

## Timing
- Reset values:
  - state IDLE, wait counter 0;
  - `mem_wb` all 0, `mem_wb_valid` 0;
  - `misaligned` 0, `bus_err` 0.
  - `dmem_req` goes low in the cycle reset is high, because it is gated by reset.
- Non-mem instruction: `mem_wb` is written on the first edge after presentation, 1-cycle latency.
- Memory op with N-cycle ack delay (N=0 means same-cycle ack):
  - `mem_stall` is high for N cycles;
  - `mem_wb` is written on the edge that ends the ack cycle.
- Timeout: `bus_err` rises WAIT_MAX cycles after WAIT entry; `mem_stall` is low in that cycle.
- Reset during WAIT: the request is abandoned, no commit, and a late ack after reset is ignored.
- ack while req is low: ignored.
- `misaligned` and `bus_err` are registered pulses, aligned with the bubble in `mem_wb`.

## Structure
- `fullsend_pkg` holds: opcode constants (OP_LOAD, OP_STORE), funct3 constants, NOP_INSN = 32'h00000013, and `mem_state_t` enum {IDLE, WAIT}.
- Sub-module `mem_lane_align` is combinational and contains both paths:
  - store side: lane, funct3 → be and wdata;
  - load side: lane, funct3, rdata → extended data.
- FSM, wait counter and MEM/WB register live in `stage4_mem`.

## Test plan
- ADD, ex_mem[2]=32'h0000_1234, ex_valid=1, no req → next edge mem_wb[1]=32'h1234, valid=1, stall never high.
- LB at ea=32'h103 with dmem_rdata=32'h80FF_0000, ack after 3 cycles:
  - stall high for 3 cycles, req held, addr=32'h100;
  - then mem_wb[2]=32'hFFFF_FF80, fwd_mem=32'hFFFF_FF80.
- LHU at ea=32'h102, rdata=32'h9ABC_5678, same-cycle ack → no stall, mem_wb[2]=32'h0000_9ABC.
- SH at ea=32'h206, rs2=32'hDEAD_BEEF → be=4'b1100, wdata=32'hBEEF_BEEF, we=1.
- SW at ea=32'h301 → no req, misaligned pulse, mem_wb[0]=32'h00000013, valid=0.
- LW with no ack and WAIT_MAX=4:
  - bus_err pulses after 4 WAIT cycles, req drops, bubble committed.
  - Repeat with reset asserted in WAIT → next cycle req=0, mem_wb=0, a late ack produces no commit.
